// File: rtl/vend_pkg.sv
// Shared definitions for the change dispenser: controller states and the
// 3-bit request entry {vend, coins} carried through the request queue.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_VEND     = 3'd1,
    ST_PAY_KICK = 3'd2,
    ST_PAY_WAIT = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  localparam int REQ_W = 3;

  typedef struct packed {
    logic       vend;
    logic [1:0] coins;
  } req_t;

  // A cycle carries work when a product is ordered or coins are owed.
  function automatic logic req_present(input logic vend_bit, input logic [1:0] coins);
    return vend_bit || (coins != 2'd0);
  endfunction

endpackage

// File: rtl/req_fifo.sv
// Small synchronous request queue with full/empty flags. Push and pop may
// occur in the same cycle, including when full, without losing data.
module req_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             empty_nxt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ZERO_CNT = (AW+1)'(0);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [AW:0]      count_s;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == ZERO_CNT);
  assign pop_ok_s  = pop && !empty;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign push_ok_s = push && (!full || pop_ok_s);
  assign dout      = mem_r[rd_ptr_r];
  assign empty_nxt = (count_s == ZERO_CNT);

  // Next occupancy from the accepted push and pop.
  always_comb begin
    count_s = count_r;
    if (push_ok_s && !pop_ok_s) begin
      count_s = count_r + 1'b1;
    end else if (!push_ok_s && pop_ok_s) begin
      count_s = count_r - 1'b1;
    end else begin
      count_s = count_r;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= ZERO_CNT;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      count_r <= count_s;
    end
  end

  // Entry storage; stale contents are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (push_ok_s && !reset) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/change_dispenser.sv
// Vending-machine product/change dispenser: queues requests and sequences the
// spiral motor and coin hopper, with sensor timeouts latching a sticky fault.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int QDEPTH  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       out,
  input  logic [1:0] changee,
  input  logic       prod_sense,
  input  logic       coin_sense,
  output logic       motor_on,
  output logic       hopper_kick,
  output logic       busy,
  output logic       fault,
  output logic       dropped
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           state_r;
  state_t           state_s;
  logic [1:0]       coin_cnt_r;
  logic [1:0]       coin_cnt_s;
  logic [7:0]       wait_cnt_r;
  logic [7:0]       wait_cnt_s;
  logic             push_s;
  logic             pop_s;
  req_t             new_req_s;
  req_t             head_s;
  logic [REQ_W-1:0] head_bits_s;
  logic             full_s;
  logic             empty_s;
  logic             empty_nxt_s;

  assign push_s    = req_present(out, changee);
  assign new_req_s = req_t'({out, changee});
  assign head_s    = req_t'(head_bits_s);

  req_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (REQ_W)
  ) u_req_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .din       (new_req_s),
    .pop       (pop_s),
    .dout      (head_bits_s),
    .full      (full_s),
    .empty     (empty_s),
    .empty_nxt (empty_nxt_s)
  );

  // Next-state, counter updates and queue pop.
  always_comb begin
    state_s    = state_r;
    coin_cnt_s = coin_cnt_r;
    wait_cnt_s = wait_cnt_r;
    pop_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s      = 1'b1;
          coin_cnt_s = head_s.coins;
          wait_cnt_s = 8'd0;
          if (head_s.vend) begin
            state_s = ST_VEND;
          end else begin
            state_s = ST_PAY_KICK;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_VEND: begin
        if (prod_sense) begin
          if (coin_cnt_r != 2'd0) begin
            state_s = ST_PAY_KICK;
          end else begin
            state_s = ST_IDLE;
          end
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_s = ST_FAULT;
        end else begin
          wait_cnt_s = wait_cnt_r + 8'd1;
        end
      end
      ST_PAY_KICK: begin
        state_s    = ST_PAY_WAIT;
        wait_cnt_s = 8'd0;
      end
      ST_PAY_WAIT: begin
        if (coin_sense) begin
          coin_cnt_s = coin_cnt_r - 2'd1;
          if (coin_cnt_s != 2'd0) begin
            state_s = ST_PAY_KICK;
          end else begin
            state_s = ST_IDLE;
          end
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_s = ST_FAULT;
        end else begin
          wait_cnt_s = wait_cnt_r + 8'd1;
        end
      end
      ST_FAULT: begin
        state_s = ST_FAULT;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      coin_cnt_r  <= 2'd0;
      wait_cnt_r  <= 8'd0;
      motor_on    <= 1'b0;
      hopper_kick <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
      dropped     <= 1'b0;
    end else begin
      state_r     <= state_s;
      coin_cnt_r  <= coin_cnt_s;
      wait_cnt_r  <= wait_cnt_s;
      motor_on    <= (state_s == ST_VEND);
      hopper_kick <= (state_s == ST_PAY_KICK);
      busy        <= (state_s != ST_IDLE) || !empty_nxt_s;
      fault       <= (state_s == ST_FAULT);
      dropped     <= push_s && full_s && !pop_s;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: expected motor-run/kick events are
// queued at stimulus time and matched against what the outputs show.
module tb_change_dispenser;

  localparam int EV_MOTOR = 1;
  localparam int EV_KICK  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       out;
  logic [1:0] changee;
  logic       prod_sense;
  logic       coin_sense;
  logic       motor_on;
  logic       hopper_kick;
  logic       busy;
  logic       fault;
  logic       dropped;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int kick_cnt  = 0;
  int motor_cnt = 0;
  int drop_cnt  = 0;
  bit prod_en = 1'b1;
  bit coin_en = 1'b1;
  bit prod_inject = 1'b0;
  bit coin_inject = 1'b0;
  int prod_tmr = 0;
  int coin_tmr = 0;
  bit rsp_mprev = 1'b0;
  bit mon_mprev = 1'b0;
  int k0, m0, d0, n;

  change_dispenser #(.TIMEOUT(16), .QDEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .out         (out),
    .changee     (changee),
    .prod_sense  (prod_sense),
    .coin_sense  (coin_sense),
    .motor_on    (motor_on),
    .hopper_kick (hopper_kick),
    .busy        (busy),
    .fault       (fault),
    .dropped     (dropped)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic sb_compare(input int ev);
    if (exp_q.size() == 0) check_eq("sb_extra_event", ev, 0);
    else check_eq("sb_event", ev, exp_q.pop_front());
  endtask

  // Sensor model: product drops 3 cycles after motor start, coin 2 after a kick.
  initial begin
    prod_sense = 1'b0;
    coin_sense = 1'b0;
    forever begin
      @(negedge clk);
      prod_sense = 1'b0;
      coin_sense = 1'b0;
      if (prod_tmr > 0) begin
        prod_tmr--;
        if (prod_tmr == 0 && prod_en) prod_sense = 1'b1;
      end
      if (coin_tmr > 0) begin
        coin_tmr--;
        if (coin_tmr == 0 && coin_en) coin_sense = 1'b1;
      end
      if (motor_on && !rsp_mprev) prod_tmr = 3;
      if (hopper_kick) coin_tmr = 2;
      rsp_mprev = motor_on;
      if (prod_inject) begin prod_sense = 1'b1; prod_inject = 1'b0; end
      if (coin_inject) begin coin_sense = 1'b1; coin_inject = 1'b0; end
    end
  end

  // Output monitor feeding the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (motor_on && !mon_mprev) begin motor_cnt++; sb_compare(EV_MOTOR); end
      if (hopper_kick) begin kick_cnt++; sb_compare(EV_KICK); end
      if (dropped) drop_cnt++;
      mon_mprev = motor_on;
    end
  end

  task automatic drive(input logic o, input logic [1:0] c, input bit expect_service);
    out = o;
    changee = c;
    if (expect_service) begin
      if (o) exp_q.push_back(EV_MOTOR);
      for (int i = 0; i < int'(c); i++) exp_q.push_back(EV_KICK);
    end
  endtask

  task automatic idle_inputs();
    out = 1'b0;
    changee = 2'd0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int cnt = 0;
    while (busy !== 1'b0 && cnt < budget) begin @(negedge clk); cnt++; end
    check_eq(tag, int'(busy), 0);
  endtask

  task automatic wait_motor(input string tag, input int budget);
    int cnt = 0;
    while (motor_on !== 1'b1 && cnt < budget) begin @(negedge clk); cnt++; end
    check_eq(tag, int'(motor_on), 1);
  endtask

  task automatic wait_motor_rise(input string tag, input int budget);
    int cnt = 0;
    while (motor_on !== 1'b0 && cnt < budget) begin @(negedge clk); cnt++; end
    wait_motor(tag, budget);
  endtask

  task automatic wait_kick(input string tag, input int budget);
    int cnt = 0;
    while (hopper_kick !== 1'b1 && cnt < budget) begin @(negedge clk); cnt++; end
    check_eq(tag, int'(hopper_kick), 1);
  endtask

  task automatic check_all_low(input string tag);
    check_eq({tag, "_motor"}, int'(motor_on), 0);
    check_eq({tag, "_kick"},  int'(hopper_kick), 0);
    check_eq({tag, "_busy"},  int'(busy), 0);
    check_eq({tag, "_fault"}, int'(fault), 0);
    check_eq({tag, "_drop"},  int'(dropped), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    check_all_low("reset");
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_reset_busy", int'(busy), 0);

    // Product plus two coins, with two-cycle service latency.
    k0 = kick_cnt; m0 = motor_cnt;
    drive(1'b1, 2'd2, 1'b1);
    @(negedge clk);
    idle_inputs();
    check_eq("lat_n1_motor", int'(motor_on), 0);
    check_eq("lat_n1_busy", int'(busy), 1);
    @(negedge clk);
    check_eq("lat_n2_motor", int'(motor_on), 1);
    wait_idle("t1_idle", 80);
    check_eq("t1_kicks", kick_cnt - k0, 2);
    check_eq("t1_motor_runs", motor_cnt - m0, 1);
    check_eq("t1_fault", int'(fault), 0);

    // Stray coin pulse during VEND must not consume a coin.
    k0 = kick_cnt;
    drive(1'b1, 2'd2, 1'b1);
    @(negedge clk);
    idle_inputs();
    wait_motor("t2_motor", 20);
    @(posedge clk);
    coin_inject = 1'b1;
    wait_idle("t2_idle", 80);
    check_eq("t2_kicks", kick_cnt - k0, 2);

    // Hopper never reports a coin: one kick, then fault 16 cycles into PAY_WAIT.
    coin_en = 1'b0;
    k0 = kick_cnt;
    drive(1'b0, 2'd3, 1'b0);
    exp_q.push_back(EV_KICK);
    @(negedge clk);
    idle_inputs();
    wait_kick("t3_kick", 20);
    n = 0;
    while (fault !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check_eq("t3_fault_latency", n, 17);
    repeat (10) @(negedge clk);
    check_eq("t3_fault_sticky", int'(fault), 1);
    check_eq("t3_kicks", kick_cnt - k0, 1);
    check_eq("t3_motor", int'(motor_on), 0);
    check_eq("t3_busy", int'(busy), 1);
    do_reset();
    coin_en = 1'b1;
    @(negedge clk);
    check_eq("t3_fault_cleared", int'(fault), 0);

    // Queue overflow while VEND waits on the product sensor.
    prod_en = 1'b0;
    m0 = motor_cnt; k0 = kick_cnt; d0 = drop_cnt;
    drive(1'b1, 2'd0, 1'b1);
    @(negedge clk);
    idle_inputs();
    wait_motor("t4_motor1", 20);
    drive(1'b1, 2'd0, 1'b1);
    @(negedge clk);
    drive(1'b1, 2'd0, 1'b1);
    @(negedge clk);
    check_eq("t4_no_drop_yet", int'(dropped), 0);
    drive(1'b1, 2'd0, 1'b0);
    @(negedge clk);
    idle_inputs();
    check_eq("t4_drop_pulse", int'(dropped), 1);
    @(negedge clk);
    check_eq("t4_drop_width", int'(dropped), 0);
    @(posedge clk);
    prod_inject = 1'b1;
    for (int r = 0; r < 2; r++) begin
      wait_motor_rise("t4_motor_next", 30);
      @(posedge clk);
      prod_inject = 1'b1;
    end
    wait_idle("t4_idle", 60);
    check_eq("t4_motor_runs", motor_cnt - m0, 3);
    check_eq("t4_drops", drop_cnt - d0, 1);
    check_eq("t4_kicks", kick_cnt - k0, 0);
    prod_en = 1'b1;

    // Push while full in the same cycle as the pop: no drop, order kept.
    coin_en = 1'b0;
    d0 = drop_cnt;
    drive(1'b0, 2'd1, 1'b1);
    @(negedge clk);
    idle_inputs();
    wait_kick("t5_kick_a", 20);
    drive(1'b1, 2'd1, 1'b1);
    @(negedge clk);
    drive(1'b1, 2'd2, 1'b1);
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    coin_inject = 1'b1;
    @(negedge clk);
    coin_en = 1'b1;
    @(negedge clk);
    drive(1'b1, 2'd3, 1'b1);
    @(negedge clk);
    idle_inputs();
    check_eq("t5_no_drop", int'(dropped), 0);
    wait_idle("t5_idle", 300);
    check_eq("t5_drops", drop_cnt - d0, 0);

    // Reset in PAY_WAIT aborts the payout; a request during reset is discarded.
    drive(1'b0, 2'd3, 1'b0);
    exp_q.push_back(EV_KICK);
    @(negedge clk);
    idle_inputs();
    wait_kick("t6_kick", 20);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 2'd1, 1'b0);
    @(negedge clk);
    check_all_low("t6_after_reset");
    reset = 1'b0;
    idle_inputs();
    k0 = kick_cnt;
    repeat (20) @(negedge clk);
    check_eq("t6_no_kick", kick_cnt - k0, 0);
    check_eq("t6_busy", int'(busy), 0);
    check_eq("t6_motor", int'(motor_on), 0);

    check_eq("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
